adc_serial_responder: RTL



---
 rtl/adc_serial_responder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/adc_serial_responder.sv
// Serial ADC responder: emulates a serial ADC on adc_cs/adc_clk/adc_sd.
// Samples arrive over a valid/ready handshake. Each frame shifts out
// LEAD_ZEROS zeros followed by the sample, MSB-first.
module adc_serial_responder #(
   parameter int unsigned DATA_BITS   = 12,
   parameter int unsigned LEAD_ZEROS  = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clock_in,
   input  logic                 reset,
   input  logic                 adc_clk,
   input  logic                 adc_cs,
   output logic                 adc_sd,
   output logic                 adc_sd_oe,
   input  logic [DATA_BITS-1:0] sample_data,
   input  logic                 sample_valid,
   output logic                 sample_ready,
   output logic                 frame_done,
   output logic                 frame_abort,
   output logic                 underrun
);

   localparam int unsigned FRAME_BITS = LEAD_ZEROS + DATA_BITS;
   localparam int unsigned CW         = $clog2(FRAME_BITS + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;

   state_t                 state, state_n;
   logic [SYNC_STAGES-1:0] cs_sync, clk_sync;
   logic                   cs_d, clk_d;
   logic                   cs_fall, cs_rise, clk_fall;
   logic [FRAME_BITS-1:0]  shreg, shreg_n;
   logic [CW-1:0]          cnt, cnt_n;
   logic                   sd_r, sd_n, oe_r, oe_n;
   logic                   done_r, done_n, abort_r, abort_n, under_r, under_n;
   logic                   full, full_n;
   logic [DATA_BITS-1:0]   hold, hold_n, last, last_n, sel;

   // Synchronize the master's cs and clk, plus one delay flop for edge detect
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         cs_sync  <= '1;
         clk_sync <= '1;
         cs_d     <= 1'b1;
         clk_d    <= 1'b1;
      end else begin
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], adc_cs};
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], adc_clk};
         cs_d     <= cs_sync[SYNC_STAGES-1];
         clk_d    <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign cs_fall  =  cs_d & ~cs_sync[SYNC_STAGES-1];
   assign cs_rise  = ~cs_d &  cs_sync[SYNC_STAGES-1];
   assign clk_fall =  clk_d & ~clk_sync[SYNC_STAGES-1];

   // State, shift register, holding register and registered outputs
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         shreg   <= '0;
         cnt     <= '0;
         sd_r    <= 1'b0;
         oe_r    <= 1'b0;
         done_r  <= 1'b0;
         abort_r <= 1'b0;
         under_r <= 1'b0;
         full    <= 1'b0;
         hold    <= '0;
         last    <= '0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         cnt     <= cnt_n;
         sd_r    <= sd_n;
         oe_r    <= oe_n;
         done_r  <= done_n;
         abort_r <= abort_n;
         under_r <= under_n;
         full    <= full_n;
         hold    <= hold_n;
         last    <= last_n;
      end
   end

   // Next-state logic: frame sequencing, sample selection and handshake
   always_comb begin
      state_n = state;
      shreg_n = shreg;
      cnt_n   = cnt;
      sd_n    = sd_r;
      oe_n    = oe_r;
      done_n  = 1'b0;
      abort_n = 1'b0;
      under_n = 1'b0;
      full_n  = full;
      hold_n  = hold;
      last_n  = last;
      sel     = last;

      // A bypass at cs fall consumes the offered sample, so the holding
      // register only accepts when no frame is being loaded this cycle.
      if (!full && sample_valid && !(state == IDLE && cs_fall)) begin
         full_n = 1'b1;
         hold_n = sample_data;
      end

      case (state)
         IDLE: begin
            sd_n = 1'b0;
            oe_n = 1'b0;
            if (cs_fall) begin
               if (full) begin
                  sel    = hold;
                  full_n = 1'b0;
               end else if (sample_valid) begin
                  sel = sample_data;
               end else begin
                  sel     = last;
                  under_n = 1'b1;
               end
               last_n  = sel;
               shreg_n = FRAME_BITS'(sel);
               sd_n    = shreg_n[FRAME_BITS-1];
               oe_n    = 1'b1;
               cnt_n   = '0;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               sd_n    = 1'b0;
               oe_n    = 1'b0;
               abort_n = 1'b1;
               state_n = IDLE;
            end else if (clk_fall) begin
               cnt_n   = cnt + 1'b1;
               shreg_n = shreg << 1;
               sd_n    = shreg[FRAME_BITS-2];
               if (cnt == CW'(FRAME_BITS - 1)) begin
                  sd_n    = 1'b0;
                  oe_n    = 1'b0;
                  done_n  = 1'b1;
                  state_n = WAIT_CS;
               end
            end
         end
         WAIT_CS: begin
            sd_n = 1'b0;
            oe_n = 1'b0;
            if (cs_rise) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign adc_sd       = sd_r;
   assign adc_sd_oe    = oe_r;
   assign sample_ready = ~full;
   assign frame_done   = done_r;
   assign frame_abort  = abort_r;
   assign underrun     = under_r;

endmodule
